// File: rtl/trigger_scheduler_if.sv
// Issue handshake between the trigger scheduler and the downstream pipe.
interface trigger_scheduler_if #(
    parameter int NUM_TRIGGERS = 16
) ();
    localparam int IW = (NUM_TRIGGERS > 1) ? $clog2(NUM_TRIGGERS) : 1;

    logic          issue_valid;
    logic          issue_ready;
    logic [IW-1:0] issue_index;

    modport master (
        output issue_valid,
        output issue_index,
        input  issue_ready
    );

    modport slave (
        input  issue_valid,
        input  issue_index,
        output issue_ready
    );
endinterface

// File: rtl/trigger_scheduler.sv
// Trigger scheduler: per-slot eligibility, arbitration, issue register
// and pending dequeue / predicate-write hazard tracking.
module trigger_scheduler #(
    parameter int NUM_TRIGGERS          = 16,
    parameter int NUM_PREDICATES        = 8,
    parameter int NUM_INPUT_CHANNELS    = 4,
    parameter int NUM_OUTPUT_CHANNELS   = 4,
    parameter int MAX_CHANNELS_TO_CHECK = 2,
    parameter int TAG_WIDTH             = 2,
    parameter int HAZARD_LATENCY        = 2,
    parameter int ARBITRATION_MODE      = 0,
    localparam int CW = $clog2(NUM_INPUT_CHANNELS + 1),
    localparam int TRIGGER_WIDTH = 1 + 2 * NUM_PREDICATES
        + MAX_CHANNELS_TO_CHECK * (CW + TAG_WIDTH + 1)
        + NUM_OUTPUT_CHANNELS
) (
    input  logic clock,
    input  logic reset,
    input  logic [NUM_TRIGGERS-1:0][TRIGGER_WIDTH-1:0] triggers,
    input  logic [NUM_TRIGGERS-1:0][NUM_INPUT_CHANNELS-1:0]
        trigger_dequeue_masks,
    input  logic [NUM_TRIGGERS-1:0][NUM_PREDICATES-1:0]
        trigger_predicate_write_masks,
    input  logic [NUM_PREDICATES-1:0] predicates,
    input  logic [NUM_INPUT_CHANNELS-1:0] input_channel_empty_status,
    input  logic [NUM_INPUT_CHANNELS-1:0][TAG_WIDTH-1:0] input_channel_tags,
    input  logic [NUM_OUTPUT_CHANNELS-1:0] output_channel_full_status,
    input  logic halt,
    input  logic flush,
    trigger_scheduler_if.master issue,
    output logic [NUM_TRIGGERS-1:0] eligible
);
    localparam int IW = (NUM_TRIGGERS > 1) ? $clog2(NUM_TRIGGERS) : 1;
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] LAT = CNT_W'(HAZARD_LATENCY);

    typedef struct packed {
        logic                                           vi;
        logic [2*NUM_PREDICATES-1:0]                    ptm;
        logic [MAX_CHANNELS_TO_CHECK-1:0][CW-1:0]       ici;
        logic [MAX_CHANNELS_TO_CHECK-1:0][TAG_WIDTH-1:0] ictv;
        logic [MAX_CHANNELS_TO_CHECK-1:0]               ictb;
        logic [NUM_OUTPUT_CHANNELS-1:0]                 oci;
    } trigger_t;

    logic [CNT_W-1:0] deq_cnt [NUM_INPUT_CHANNELS];
    logic [CNT_W-1:0] wr_cnt  [NUM_PREDICATES];
    logic [NUM_INPUT_CHANNELS-1:0] deq_busy;
    logic [NUM_PREDICATES-1:0]     wr_busy;

    logic [IW-1:0] rr_pointer;
    logic [IW-1:0] rr_base;
    logic [IW-1:0] winner;
    logic [IW-1:0] cand;
    int            scan_idx;
    logic          found;
    logic          hs;
    logic          load;

    assign hs   = issue.issue_valid && issue.issue_ready;
    assign load = (!issue.issue_valid || hs) && !halt;

    always_comb begin
        deq_busy = '0;
        wr_busy  = '0;
        for (int c = 0; c < NUM_INPUT_CHANNELS; c++)
            deq_busy[c] = deq_cnt[c] != '0;
        for (int p = 0; p < NUM_PREDICATES; p++)
            wr_busy[p] = wr_cnt[p] != '0;
    end

    for (genvar t = 0; t < NUM_TRIGGERS; t++) begin : g_slot
        trigger_t                  trg;
        logic [NUM_PREDICATES-1:0] true_m;
        logic [NUM_PREDICATES-1:0] false_m;
        logic                      chan_ok;

        assign trg     = trigger_t'(triggers[t]);
        assign true_m  = trg.ptm[2*NUM_PREDICATES-1 -: NUM_PREDICATES];
        assign false_m = trg.ptm[NUM_PREDICATES-1:0];

        always_comb begin
            chan_ok = 1'b1;
            for (int s = 0; s < MAX_CHANNELS_TO_CHECK; s++) begin
                for (int c = 0; c < NUM_INPUT_CHANNELS; c++) begin
                    if (trg.ici[s] == CW'(c + 1)) begin
                        if (input_channel_empty_status[c] || deq_busy[c])
                            chan_ok = 1'b0;
                        if ((input_channel_tags[c] == trg.ictv[s])
                            != trg.ictb[s])
                            chan_ok = 1'b0;
                    end
                end
            end
        end

        assign eligible[t] = trg.vi && chan_ok
            && ((true_m & ~predicates) == '0)
            && ((false_m & predicates) == '0)
            && (((true_m | false_m) & wr_busy) == '0)
            && ((trg.oci & output_channel_full_status) == '0);
    end

    // A handshaking slot counts as the last winner for this edge's search.
    assign rr_base = hs ? issue.issue_index : rr_pointer;

    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = 0;
        cand     = '0;
        for (int k = 0; k < NUM_TRIGGERS; k++) begin
            if (ARBITRATION_MODE == 0) begin
                scan_idx = k;
            end else begin
                scan_idx = int'(rr_base) + 1 + k;
                if (scan_idx >= NUM_TRIGGERS)
                    scan_idx = scan_idx - NUM_TRIGGERS;
            end
            cand = IW'(scan_idx);
            if (!found && eligible[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            issue.issue_valid <= 1'b0;
            issue.issue_index <= '0;
            rr_pointer        <= IW'(NUM_TRIGGERS - 1);
            for (int c = 0; c < NUM_INPUT_CHANNELS; c++) deq_cnt[c] <= '0;
            for (int p = 0; p < NUM_PREDICATES; p++) wr_cnt[p] <= '0;
        end else if (flush) begin
            issue.issue_valid <= 1'b0;
            for (int c = 0; c < NUM_INPUT_CHANNELS; c++) deq_cnt[c] <= '0;
            for (int p = 0; p < NUM_PREDICATES; p++) wr_cnt[p] <= '0;
        end else begin
            if (load) begin
                issue.issue_valid <= |eligible;
                if (|eligible)
                    issue.issue_index <= winner;
            end else if (hs) begin
                issue.issue_valid <= 1'b0;
            end
            if (hs)
                rr_pointer <= issue.issue_index;
            for (int c = 0; c < NUM_INPUT_CHANNELS; c++) begin
                if (hs && trigger_dequeue_masks[issue.issue_index][c])
                    deq_cnt[c] <= LAT;
                else if (deq_cnt[c] != '0)
                    deq_cnt[c] <= deq_cnt[c] - 1'b1;
            end
            for (int p = 0; p < NUM_PREDICATES; p++) begin
                if (hs && trigger_predicate_write_masks[issue.issue_index][p])
                    wr_cnt[p] <= LAT;
                else if (wr_cnt[p] != '0)
                    wr_cnt[p] <= wr_cnt[p] - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_trigger_scheduler.sv
// Bench for trigger_scheduler: fixed-priority and round-robin instances
// share stimulus; a behavioural model plus vector table and directed cases.
module tb_trigger_scheduler;
    localparam int N  = 16;
    localparam int P  = 8;
    localparam int NI = 4;
    localparam int NO = 4;
    localparam int MC = 2;
    localparam int TW = 2;
    localparam int HL = 2;
    localparam int CW = 3;
    localparam int TRW = 1 + 2 * P + MC * (CW + TW + 1) + NO;

    typedef struct packed {
        logic                     vi;
        logic [2*P-1:0]           ptm;
        logic [MC-1:0][CW-1:0]    ici;
        logic [MC-1:0][TW-1:0]    ictv;
        logic [MC-1:0]            ictb;
        logic [NO-1:0]            oci;
    } trig_t;

    typedef struct {
        trig_t                 g;
        logic [P-1:0]          pred;
        logic [NI-1:0]         empty;
        logic [NI-1:0][TW-1:0] tags;
        logic [NO-1:0]         full;
        bit                    exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, halt, flush, ready;
    trig_t [N-1:0]            trig;
    logic [N-1:0][TRW-1:0]    trig_bits;
    logic [N-1:0][NI-1:0]     deq_m;
    logic [N-1:0][P-1:0]      wr_m;
    logic [P-1:0]             pred;
    logic [NI-1:0]            empty;
    logic [NI-1:0][TW-1:0]    tags;
    logic [NO-1:0]            full;
    logic [N-1:0]             elig_fp, elig_rr;

    assign trig_bits = trig;

    trigger_scheduler_if #(.NUM_TRIGGERS(N)) if_fp ();
    trigger_scheduler_if #(.NUM_TRIGGERS(N)) if_rr ();
    assign if_fp.issue_ready = ready;
    assign if_rr.issue_ready = ready;

    trigger_scheduler #(.ARBITRATION_MODE(0)) u_fp (
        .clock(clk), .reset(reset), .triggers(trig_bits),
        .trigger_dequeue_masks(deq_m),
        .trigger_predicate_write_masks(wr_m),
        .predicates(pred), .input_channel_empty_status(empty),
        .input_channel_tags(tags), .output_channel_full_status(full),
        .halt(halt), .flush(flush), .issue(if_fp), .eligible(elig_fp)
    );

    trigger_scheduler #(.ARBITRATION_MODE(1)) u_rr (
        .clock(clk), .reset(reset), .triggers(trig_bits),
        .trigger_dequeue_masks(deq_m),
        .trigger_predicate_write_masks(wr_m),
        .predicates(pred), .input_channel_empty_status(empty),
        .input_channel_tags(tags), .output_channel_full_status(full),
        .halt(halt), .flush(flush), .issue(if_rr), .eligible(elig_rr)
    );

    int m_valid [2];
    int m_idx   [2];
    int m_rr    [2];
    int m_deq   [2][NI];
    int m_wr    [2][P];
    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    vec_t vt [12];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s @cycle %0d: got %0h expected %0h",
                      name, cyc, act, exp);
    endtask

    function automatic bit model_elig(int m, int t);
        trig_t g;
        int ch;
        g = trig[t];
        if (!g.vi) return 1'b0;
        for (int p = 0; p < P; p++) begin
            if (g.ptm[P+p] && !pred[p]) return 1'b0;
            if (g.ptm[p] && pred[p]) return 1'b0;
            if ((g.ptm[P+p] || g.ptm[p]) && m_wr[m][p] > 0) return 1'b0;
        end
        for (int s = 0; s < MC; s++) begin
            if (g.ici[s] == 0) continue;
            ch = int'(g.ici[s]) - 1;
            if (ch >= NI) continue;
            if (empty[ch]) return 1'b0;
            if (m_deq[m][ch] > 0) return 1'b0;
            if (g.ictb[s] ? (tags[ch] != g.ictv[s])
                          : (tags[ch] == g.ictv[s])) return 1'b0;
        end
        for (int o = 0; o < NO; o++)
            if (g.oci[o] && full[o]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 0;
            m_idx[m]   = 0;
            m_rr[m]    = N - 1;
            for (int c = 0; c < NI; c++) m_deq[m][c] = 0;
            for (int p = 0; p < P; p++) m_wr[m][p] = 0;
        end
    endtask

    task automatic model_step();
        bit el [N];
        bit any, hs;
        int win, base, j, old;
        for (int m = 0; m < 2; m++) begin
            any = 1'b0;
            win = -1;
            for (int t = 0; t < N; t++) begin
                el[t] = model_elig(m, t);
                any   = any | el[t];
            end
            hs = (m_valid[m] != 0) && ready;
            if (m == 0) begin
                for (int t = 0; t < N; t++)
                    if (win < 0 && el[t]) win = t;
            end else begin
                base = hs ? m_idx[m] : m_rr[m];
                for (int k = 1; k <= N; k++) begin
                    j = (base + k) % N;
                    if (win < 0 && el[j]) win = j;
                end
            end
            if (reset) begin
                m_valid[m] = 0;
                m_idx[m]   = 0;
                m_rr[m]    = N - 1;
                for (int c = 0; c < NI; c++) m_deq[m][c] = 0;
                for (int p = 0; p < P; p++) m_wr[m][p] = 0;
                continue;
            end
            if (flush) begin
                m_valid[m] = 0;
                for (int c = 0; c < NI; c++) m_deq[m][c] = 0;
                for (int p = 0; p < P; p++) m_wr[m][p] = 0;
                continue;
            end
            old = m_idx[m];
            for (int c = 0; c < NI; c++)
                if (hs && deq_m[old][c]) m_deq[m][c] = HL;
                else if (m_deq[m][c] > 0) m_deq[m][c]--;
            for (int p = 0; p < P; p++)
                if (hs && wr_m[old][p]) m_wr[m][p] = HL;
                else if (m_wr[m][p] > 0) m_wr[m][p]--;
            if (hs) m_rr[m] = old;
            if ((m_valid[m] == 0 || hs) && !halt) begin
                m_valid[m] = any ? 1 : 0;
                if (any) m_idx[m] = win;
            end else if (hs) begin
                m_valid[m] = 0;
            end
        end
    endtask

    task automatic compare_model();
        logic [N-1:0] e0, e1;
        for (int t = 0; t < N; t++) begin
            e0[t] = model_elig(0, t);
            e1[t] = model_elig(1, t);
        end
        chk("fp_valid", 32'(if_fp.issue_valid), 32'(m_valid[0]));
        chk("fp_index", 32'(if_fp.issue_index), 32'(m_idx[0]));
        chk("fp_eligible", 32'(elig_fp), 32'(e0));
        chk("rr_valid", 32'(if_rr.issue_valid), 32'(m_valid[1]));
        chk("rr_index", 32'(if_rr.issue_index), 32'(m_idx[1]));
        chk("rr_eligible", 32'(elig_rr), 32'(e1));
    endtask

    task automatic step();
        @(negedge clk);
        compare_model();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_all();
        trig  = '0;
        deq_m = '0;
        wr_m  = '0;
        pred  = '0;
        empty = '0;
        tags  = '0;
        full  = '0;
        halt  = 1'b0;
        flush = 1'b0;
        ready = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    function automatic vec_t vbase();
        vec_t v;
        v.g    = '0;
        v.g.vi = 1'b1;
        v.pred = '0;
        v.empty = '0;
        v.tags = '0;
        v.full = '0;
        v.exp  = 1'b1;
        return v;
    endfunction

    task automatic randomize_triggers();
        for (int t = 0; t < N; t++) begin
            trig[t].vi = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < 2 * P; b++)
                trig[t].ptm[b] = ($urandom_range(0, 7) == 0);
            for (int s = 0; s < MC; s++) begin
                trig[t].ici[s]  = ($urandom_range(0, 2) == 0)
                                  ? CW'($urandom_range(1, NI)) : '0;
                trig[t].ictv[s] = TW'($urandom_range(0, 3));
                trig[t].ictb[s] = 1'($urandom_range(0, 1));
            end
            for (int o = 0; o < NO; o++)
                trig[t].oci[o] = ($urandom_range(0, 5) == 0);
            for (int c = 0; c < NI; c++)
                deq_m[t][c] = ($urandom_range(0, 2) == 0);
            for (int p = 0; p < P; p++)
                wr_m[t][p] = ($urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_all();
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();
        reset = 1'b0;

        // Reset state.
        chk("reset_valid", 32'(if_fp.issue_valid), 32'd0);
        chk("reset_index", 32'(if_fp.issue_index), 32'd0);

        // Eligibility vectors on slot 1 with no hazards outstanding.
        for (int i = 0; i < 12; i++) vt[i] = vbase();
        vt[1].g.vi = 1'b0; vt[1].exp = 1'b0;
        vt[2].g.ptm[P+3] = 1'b1; vt[2].pred[3] = 1'b1;
        vt[3].g.ptm[P+3] = 1'b1; vt[3].exp = 1'b0;
        vt[4].g.ptm[5] = 1'b1; vt[4].pred[5] = 1'b1; vt[4].exp = 1'b0;
        vt[5].g.ici[0] = 3'd2; vt[5].g.ictb[0] = 1'b1;
        vt[6] = vt[5]; vt[6].empty[1] = 1'b1; vt[6].exp = 1'b0;
        vt[7].g.ici[0] = 3'd2; vt[7].g.ictv[0] = 2'd2;
        vt[7].tags[1] = 2'd2; vt[7].exp = 1'b0;
        vt[8] = vt[7]; vt[8].tags[1] = 2'd1; vt[8].exp = 1'b1;
        vt[9].g.oci = 4'b0100; vt[9].full = 4'b0100; vt[9].exp = 1'b0;
        vt[10].g.oci = 4'b0100; vt[10].full = 4'b1011;
        vt[11].g.ici[1] = 3'd4; vt[11].g.ictb[1] = 1'b1;
        vt[11].g.ictv[1] = 2'd3; vt[11].tags[3] = 2'd3;
        for (int i = 0; i < 12; i++) begin
            trig    = '0;
            trig[1] = vt[i].g;
            pred    = vt[i].pred;
            empty   = vt[i].empty;
            tags    = vt[i].tags;
            full    = vt[i].full;
            #1;
            chk($sformatf("vec%0d_elig", i), 32'(elig_fp[1]),
                32'(vt[i].exp));
            step();
        end

        // Fixed priority picks the lowest of slots 3 and 5.
        clear_all();
        do_reset();
        trig[3].vi = 1'b1;
        trig[5].vi = 1'b1;
        step();
        chk("fp_pick_valid", 32'(if_fp.issue_valid), 32'd1);
        chk("fp_pick_index", 32'(if_fp.issue_index), 32'd3);

        // Round robin alternates between two always-eligible slots.
        clear_all();
        do_reset();
        trig[0].vi = 1'b1;
        trig[1].vi = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("rr_seq%0d", i), 32'(if_rr.issue_index),
                32'(i % 2));
        end

        // Dequeue hazard blocks a reader of the same channel for 2 cycles.
        clear_all();
        do_reset();
        trig[2].vi = 1'b1;
        deq_m[2]   = 4'b0010;
        step();
        chk("haz_first_index", 32'(if_fp.issue_index), 32'd2);
        trig[2].vi = 1'b0;
        step();
        trig[4].vi      = 1'b1;
        trig[4].ici[0]  = 3'd2;
        trig[4].ictb[0] = 1'b1;
        #1;
        chk("haz_blocked0", 32'(elig_fp[4]), 32'd0);
        step();
        chk("haz_blocked1", 32'(elig_fp[4]), 32'd0);
        step();
        chk("haz_released", 32'(elig_fp[4]), 32'd1);
        step();
        chk("haz_issue_valid", 32'(if_fp.issue_valid), 32'd1);
        chk("haz_issue_index", 32'(if_fp.issue_index), 32'd4);

        // Stall holds the presented trigger and loads no counters.
        clear_all();
        do_reset();
        ready           = 1'b0;
        trig[6].vi      = 1'b1;
        deq_m[6]        = 4'b0001;
        trig[7].ici[0]  = 3'd1;
        trig[7].ictb[0] = 1'b1;
        step();
        chk("stall_index", 32'(if_fp.issue_index), 32'd6);
        for (int i = 0; i < 3; i++) begin
            trig[0].vi = (i % 2 == 0);
            trig[7].vi = (i % 2 == 0);
            #1;
            chk($sformatf("stall_elig7_%0d", i), 32'(elig_fp[7]),
                32'(i % 2 == 0));
            step();
            chk($sformatf("stall_valid%0d", i), 32'(if_fp.issue_valid), 32'd1);
            chk($sformatf("stall_hold%0d", i), 32'(if_fp.issue_index), 32'd6);
        end

        // Flush clears hazards and the issue register; reset drops a stall.
        clear_all();
        do_reset();
        trig[2].vi      = 1'b1;
        deq_m[2]        = 4'b0010;
        trig[3].vi      = 1'b1;
        trig[4].vi      = 1'b1;
        trig[4].ici[0]  = 3'd2;
        trig[4].ictb[0] = 1'b1;
        step();
        trig[2].vi = 1'b0;
        step();
        chk("flush_pre_index", 32'(if_fp.issue_index), 32'd3);
        chk("flush_pre_haz", 32'(elig_fp[4]), 32'd0);
        ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", 32'(if_fp.issue_valid), 32'd0);
        chk("flush_haz_clear", 32'(elig_fp[4]), 32'd1);
        step();
        chk("stall_again", 32'(if_fp.issue_valid), 32'd1);
        do_reset();
        chk("midstall_reset_valid", 32'(if_fp.issue_valid), 32'd0);
        chk("midstall_reset_index", 32'(if_fp.issue_index), 32'd0);

        // Randomized run against the model.
        clear_all();
        for (int i = 0; i < 600; i++) begin
            if (i % 25 == 0) randomize_triggers();
            pred  = P'($urandom);
            for (int c = 0; c < NI; c++)
                empty[c] = ($urandom_range(0, 3) == 0);
            tags  = (NI * TW)'($urandom);
            for (int o = 0; o < NO; o++)
                full[o] = ($urandom_range(0, 3) == 0);
            ready = ($urandom_range(0, 3) != 0);
            halt  = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 49) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
